fetch_ctrl: RTL and testbench

Program-counter and fetch-control stage for the 9-bit core. Drives the 7-bit instruction address into the combinational instruction ROM, consumes the returned instruction word and resolves branches through a 16-entry branch-target lookup table. Tracks run/done status and counts retired instructions. Program start, halt and load stalls are all managed here.

---
 rtl/fetch_ctrl.sv | 109 ++++++++++
 tb/tb_fetch_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Program counter and fetch control for the 9-bit core: sequencing, branch
// resolution through a 16-entry target LUT, run/done status and a retired count.
module fetch_ctrl (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic [6:0]  StartAddr,
   input  logic [8:0]  Instr,
   input  logic        ZeroFlag,
   input  logic        Stall,
   input  logic        LutWe,
   input  logic [3:0]  LutWIdx,
   input  logic [6:0]  LutWData,
   output logic [6:0]  InstAddress,
   output logic        Running,
   output logic        Done,
   output logic [15:0] InstCount
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [6:0]  pc_q, pc_d;
   logic [15:0] cnt_q, cnt_d;
   logic        running_q, running_d;
   logic        done_q, done_d;
   logic [6:0]  lut_q [16];
   logic [6:0]  lut_d [16];
   logic        taken;
   logic [6:0]  target;

   always_comb begin
      taken  = (Instr[8:6] == 3'b110) | ((Instr[8:6] == 3'b111) & ZeroFlag);
      // Target is read from the registered LUT, so a same-cycle write is not seen.
      target = lut_q[Instr[3:0]];

      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (Start) begin
               pc_d    = StartAddr;
               cnt_d   = 16'd0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!Stall) begin
               if (cnt_q != 16'hFFFF) begin
                  cnt_d = cnt_q + 16'd1;
               end
               if (taken) begin
                  // A branch to itself is the program's halt idiom.
                  if (target == pc_q) begin
                     state_d = ST_DONE;
                  end else begin
                     pc_d = target;
                  end
               end else if (pc_q == 7'd127) begin
                  state_d = ST_DONE;
               end else begin
                  pc_d = pc_q + 7'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      running_d = (state_d == ST_RUN);
      done_d    = (state_d == ST_DONE);

      lut_d = lut_q;
      if (LutWe) begin
         lut_d[LutWIdx] = LutWData;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= ST_IDLE;
         pc_q      <= 7'd0;
         cnt_q     <= 16'd0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            lut_q[i] <= 7'd0;
         end
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         cnt_q     <= cnt_d;
         running_q <= running_d;
         done_q    <= done_d;
         lut_q     <= lut_d;
      end
   end

   assign InstAddress = pc_q;
   assign Running     = running_q;
   assign Done        = done_q;
   assign InstCount   = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, randomized run against a
// reference model, and a counter saturation run.
module tb_fetch_ctrl;

   logic        Clk;
   logic        Reset;
   logic        Start;
   logic [6:0]  StartAddr;
   logic [8:0]  Instr;
   logic        ZeroFlag;
   logic        Stall;
   logic        LutWe;
   logic [3:0]  LutWIdx;
   logic [6:0]  LutWData;
   logic [6:0]  InstAddress;
   logic        Running;
   logic        Done;
   logic [15:0] InstCount;

   fetch_ctrl dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .Start       (Start),
      .StartAddr   (StartAddr),
      .Instr       (Instr),
      .ZeroFlag    (ZeroFlag),
      .Stall       (Stall),
      .LutWe       (LutWe),
      .LutWIdx     (LutWIdx),
      .LutWData    (LutWData),
      .InstAddress (InstAddress),
      .Running     (Running),
      .Done        (Done),
      .InstCount   (InstCount)
   );

   // ---------------- clock ----------------
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // mode: 0 = idle, 1 = running, 2 = done
   int m_pc, m_mode, m_cnt;
   int m_lut [16];

   task automatic model_edge();
      int op, tgt;
      bit tk;
      if (Reset) begin
         m_pc = 0; m_mode = 0; m_cnt = 0;
         foreach (m_lut[i]) m_lut[i] = 0;
         return;
      end
      op  = int'(Instr) / 64;
      tgt = m_lut[int'(Instr) % 16];
      tk  = (op == 6) || (op == 7 && ZeroFlag);
      if (m_mode != 1) begin
         if (Start) begin
            m_pc = StartAddr; m_cnt = 0; m_mode = 1;
         end
      end else if (!Stall) begin
         m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
         if (tk) begin
            if (tgt == m_pc) m_mode = 2;
            else m_pc = tgt;
         end else if (m_pc == 127) begin
            m_mode = 2;
         end else begin
            m_pc = m_pc + 1;
         end
      end
      if (LutWe) m_lut[LutWIdx] = LutWData;
   endtask

   task automatic step();
      model_edge();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_inputs();
      Reset = 0; Start = 0; StartAddr = 0; Instr = 0; ZeroFlag = 0;
      Stall = 0; LutWe = 0; LutWIdx = 0; LutWData = 0;
   endtask

   task automatic check_model(input string tag);
      check({tag, " pc"},   InstAddress, m_pc);
      check({tag, " run"},  Running,     (m_mode == 1));
      check({tag, " done"}, Done,        (m_mode == 2));
      check({tag, " cnt"},  InstCount,   m_cnt);
      check({tag, " excl"}, Running & Done, 0);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        rst, start;
      logic [6:0]  saddr;
      logic [8:0]  instr;
      logic        zf, stall, we;
      logic [3:0]  widx;
      logic [6:0]  wdata;
      logic [6:0]  e_pc;
      logic        e_run, e_done;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vecs[$];

   localparam logic [8:0] NB = 9'h000;

   function automatic logic [8:0] br(input logic [3:0] i);
      return {3'b110, 2'b00, i};
   endfunction

   function automatic logic [8:0] brz(input logic [3:0] i);
      return {3'b111, 2'b00, i};
   endfunction

   task automatic add(input logic rst, input logic start, input logic [6:0] saddr,
                      input logic [8:0] instr, input logic zf, input logic stall,
                      input logic we, input logic [3:0] widx, input logic [6:0] wdata,
                      input logic [6:0] e_pc, input logic e_run, input logic e_done,
                      input logic [15:0] e_cnt);
      vec_t v;
      v.rst = rst; v.start = start; v.saddr = saddr; v.instr = instr; v.zf = zf;
      v.stall = stall; v.we = we; v.widx = widx; v.wdata = wdata;
      v.e_pc = e_pc; v.e_run = e_run; v.e_done = e_done; v.e_cnt = e_cnt;
      vecs.push_back(v);
   endtask

   initial begin
      idle_inputs();

      //  rst st saddr instr    zf st we idx data  | pc  run done cnt
      add(1, 1, 50,  NB,      0, 0, 0, 0, 0,     0,   0, 0, 0);   // reset beats start
      add(0, 0, 0,   NB,      0, 0, 0, 0, 0,     0,   0, 0, 0);
      add(0, 1, 0,   NB,      0, 0, 0, 0, 0,     0,   1, 0, 0);
      for (int i = 1; i <= 5; i++)
         add(0, 0, 0, NB,     0, 0, 0, 0, 0,     7'(i), 1, 0, 16'(i));
      add(0, 0, 0,   NB,      0, 0, 1, 3, 40,    6,   1, 0, 6);
      add(0, 0, 0,   NB,      0, 0, 1, 2, 25,    7,   1, 0, 7);
      add(0, 0, 0,   NB,      0, 0, 1, 6, 39,    8,   1, 0, 8);
      add(0, 1, 33,  NB,      0, 0, 0, 0, 0,     9,   1, 0, 9);   // start ignored in run
      add(0, 0, 0,   NB,      0, 0, 1, 7, 33,    10,  1, 0, 10);
      add(0, 0, 0,   br(7),   0, 0, 0, 0, 0,     33,  1, 0, 11);
      add(0, 0, 0,   brz(3),  0, 0, 0, 0, 0,     34,  1, 0, 12);
      add(0, 0, 0,   br(7),   0, 0, 0, 0, 0,     33,  1, 0, 13);
      add(0, 0, 0,   brz(3),  1, 0, 0, 0, 0,     40,  1, 0, 14);
      add(0, 0, 0,   NB,      0, 0, 1, 8, 12,    41,  1, 0, 15);
      add(0, 0, 0,   br(8),   0, 0, 0, 0, 0,     12,  1, 0, 16);
      add(0, 0, 0,   br(3),   0, 1, 0, 0, 0,     12,  1, 0, 16);  // stalled
      add(0, 0, 0,   br(3),   0, 1, 0, 0, 0,     12,  1, 0, 16);
      add(0, 0, 0,   NB,      0, 0, 0, 0, 0,     13,  1, 0, 17);
      add(0, 0, 0,   br(6),   0, 0, 1, 6, 51,    39,  1, 0, 18);  // old LUT entry
      add(0, 0, 0,   br(6),   0, 0, 0, 0, 0,     51,  1, 0, 19);
      add(0, 0, 0,   br(2),   0, 0, 0, 0, 0,     25,  1, 0, 20);
      add(0, 0, 0,   brz(2),  1, 0, 0, 0, 0,     25,  0, 1, 21);  // halt
      add(0, 0, 0,   NB,      0, 0, 0, 0, 0,     25,  0, 1, 21);
      add(0, 1, 10,  NB,      0, 0, 0, 0, 0,     10,  1, 0, 0);
      add(0, 0, 0,   NB,      0, 0, 0, 0, 0,     11,  1, 0, 1);
      add(1, 0, 0,   NB,      0, 0, 0, 0, 0,     0,   0, 0, 0);   // reset mid-run
      add(0, 1, 126, NB,      0, 0, 0, 0, 0,     126, 1, 0, 0);
      add(0, 0, 0,   NB,      0, 0, 0, 0, 0,     127, 1, 0, 1);
      add(0, 0, 0,   NB,      0, 0, 0, 0, 0,     127, 0, 1, 2);   // no wrap
      add(0, 0, 0,   br(0),   1, 0, 0, 0, 0,     127, 0, 1, 2);
      add(0, 1, 5,   NB,      0, 0, 0, 0, 0,     5,   1, 0, 0);
      add(0, 0, 0,   br(3),   0, 0, 0, 0, 0,     0,   1, 0, 1);   // LUT was cleared
      add(0, 0, 0,   brz(3),  1, 0, 0, 0, 0,     0,   0, 1, 2);
      add(0, 1, 127, NB,      0, 0, 0, 0, 0,     127, 1, 0, 0);
      add(0, 0, 0,   brz(0),  0, 0, 0, 0, 0,     127, 0, 1, 1);
      add(0, 1, 3,   NB,      0, 1, 0, 0, 0,     3,   1, 0, 0);   // stall irrelevant in done

      foreach (vecs[k]) begin
         Reset = vecs[k].rst; Start = vecs[k].start; StartAddr = vecs[k].saddr;
         Instr = vecs[k].instr; ZeroFlag = vecs[k].zf; Stall = vecs[k].stall;
         LutWe = vecs[k].we; LutWIdx = vecs[k].widx; LutWData = vecs[k].wdata;
         step();
         check($sformatf("vec%0d pc", k),   InstAddress, vecs[k].e_pc);
         check($sformatf("vec%0d run", k),  Running,     vecs[k].e_run);
         check($sformatf("vec%0d done", k), Done,        vecs[k].e_done);
         check($sformatf("vec%0d cnt", k),  InstCount,   vecs[k].e_cnt);
      end

      // ---------------- randomized run against the model ----------------
      idle_inputs();
      Reset = 1;
      step();
      check_model("rand_reset");
      for (int c = 0; c < 3000; c++) begin
         int r;
         Reset     = ($urandom_range(0, 199) == 0);
         Start     = ($urandom_range(0, 11) == 0);
         StartAddr = 7'($urandom_range(0, 127));
         r = $urandom_range(0, 3);
         if (r < 2)       Instr = {3'($urandom_range(0, 5)), 6'($urandom)};
         else if (r == 2) Instr = {3'b110, 6'($urandom)};
         else             Instr = {3'b111, 6'($urandom)};
         ZeroFlag  = 1'($urandom);
         Stall     = ($urandom_range(0, 4) == 0);
         LutWe     = ($urandom_range(0, 3) == 0);
         LutWIdx   = 4'($urandom);
         LutWData  = 7'($urandom);
         step();
         check_model($sformatf("rand%0d", c));
      end

      // ---------------- counter saturation ----------------
      idle_inputs();
      Reset = 1;
      step();
      Reset = 0; LutWe = 1; LutWIdx = 0; LutWData = 20;
      step();
      LutWIdx = 1; LutWData = 21;
      step();
      LutWe = 0; Start = 1; StartAddr = 20;
      step();
      Start = 0;
      for (int c = 0; c < 65534; c++) begin
         Instr = (m_pc == 20) ? br(1) : br(0);
         step();
      end
      check("sat_pre cnt", InstCount, 65534);
      Instr = (m_pc == 20) ? br(1) : br(0);
      step();
      check("sat_max cnt", InstCount, 65535);
      Instr = (m_pc == 20) ? br(1) : br(0);
      step();
      check("sat_hold cnt", InstCount, 65535);
      check("sat_hold run", Running, 1);
      check("sat_hold pc", InstAddress, m_pc);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
